// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: state encoding, grant codes and request holdoff shared by the burst responder
package mem_burst_pkg;
    typedef enum logic [2:0] {IDLE, WR, WR_TAIL, RD, RD_TAIL, DONE} state_t;
    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;
    localparam int HOLDOFF_CYCLES = 2;
endpackage

// File: rtl/mem_burst_arb.sv
// mem_burst_arb: round-robin read/write grant with a post-burst request holdoff
module mem_burst_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic idle,
    input  logic done,
    input  logic wr_req,
    input  logic rd_req,
    output logic grant,
    output logic grant_sel
);
    import mem_burst_pkg::*;
    logic last_grant;
    logic [1:0] hold;
    assign grant_sel = (wr_req && rd_req) ? ~last_grant : (wr_req ? GRANT_WR : GRANT_RD);
    assign grant = idle && hold == 2'd0 && (wr_req || rd_req);
    // remember the last served channel; block sampling for the DONE cycle and the IDLE cycle after it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_RD;
            hold <= 2'd0;
        end else begin
            if (grant) last_grant <= grant_sel;
            hold <= done ? 2'(HOLDOFF_CYCLES - 1) : (hold != 2'd0 ? hold - 2'd1 : 2'd0);
        end
    end
endmodule

// File: rtl/mem_burst_responder.sv
// mem_burst_responder: burst protocol responder onto a 1-cycle-latency memory port; MEM_BURST_STAT_EN adds burst/beat counters
module mem_burst_responder #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS = 24,
    parameter int BUSRT_BITS = 10
) (
    input  logic mem_clk,
    input  logic rst_n,
    input  logic rd_burst_req,
    input  logic [BUSRT_BITS-1:0] rd_burst_len,
    input  logic [ADDR_BITS-1:0] rd_burst_addr,
    output logic rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data,
    output logic rd_burst_finish,
    input  logic wr_burst_req,
    input  logic [BUSRT_BITS-1:0] wr_burst_len,
    input  logic [ADDR_BITS-1:0] wr_burst_addr,
    output logic wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
    output logic wr_burst_finish,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic mem_we,
    output logic [MEM_DATA_BITS-1:0] mem_wdata,
    output logic mem_re,
    input  logic [MEM_DATA_BITS-1:0] mem_rdata
`ifdef MEM_BURST_STAT_EN
    ,
    output logic [31:0] wr_burst_cnt,
    output logic [31:0] rd_burst_cnt,
    output logic [31:0] beat_cnt
`endif
);
    import mem_burst_pkg::*;
    state_t state, state_nx;
    logic [ADDR_BITS-1:0] base, req_addr;
    logic [BUSRT_BITS-1:0] len, cnt, cnt_d, req_len;
    logic is_wr, grant, grant_sel, last_beat;

    mem_burst_arb u_arb (
        .clk(mem_clk),
        .rst_n(rst_n),
        .idle(state == IDLE),
        .done(state == DONE),
        .wr_req(wr_burst_req),
        .rd_req(rd_burst_req),
        .grant(grant),
        .grant_sel(grant_sel)
    );

    assign req_len = grant_sel == GRANT_WR ? wr_burst_len : rd_burst_len;
    assign req_addr = grant_sel == GRANT_WR ? wr_burst_addr : rd_burst_addr;
    assign last_beat = cnt == len - 1'b1;
    assign wr_burst_data_req = state == WR;
    assign mem_re = state == RD;
    assign wr_burst_finish = state == DONE && is_wr;
    assign rd_burst_finish = state == DONE && !is_wr;
    // write beats land one cycle after their request, so they use the delayed beat index
    assign mem_addr = mem_we ? base + ADDR_BITS'(cnt_d) : (mem_re ? base + ADDR_BITS'(cnt) : '0);
    assign mem_wdata = mem_we ? wr_burst_data : '0;
    assign rd_burst_data = rd_burst_data_valid ? mem_rdata : '0;

    // beat sequencer next-state: zero-length bursts skip straight to DONE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = req_len == '0 ? DONE : (grant_sel == GRANT_WR ? WR : RD);
            WR:      if (last_beat) state_nx = WR_TAIL;
            WR_TAIL: state_nx = DONE;
            RD:      if (last_beat) state_nx = RD_TAIL;
            RD_TAIL: state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // state, latched burst parameters, beat counter and the one-cycle delayed strobes
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            base <= '0;
            len <= '0;
            cnt <= '0;
            cnt_d <= '0;
            is_wr <= 1'b0;
            mem_we <= 1'b0;
            rd_burst_data_valid <= 1'b0;
        end else begin
            state <= state_nx;
            cnt_d <= cnt;
            mem_we <= wr_burst_data_req;
            rd_burst_data_valid <= mem_re;
            if (grant) begin
                base <= req_addr;
                len <= req_len;
                cnt <= '0;
                is_wr <= grant_sel == GRANT_WR;
            end else if (wr_burst_data_req || mem_re) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef MEM_BURST_STAT_EN
    // free-running statistics: finished bursts per channel and memory beats
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_burst_cnt <= '0;
            rd_burst_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            wr_burst_cnt <= wr_burst_cnt + 32'(wr_burst_finish);
            rd_burst_cnt <= rd_burst_cnt + 32'(rd_burst_finish);
            beat_cnt <= beat_cnt + 32'(mem_we || mem_re);
        end
    end
`endif
endmodule

// File: tb/tb_mem_burst_responder.sv
// tb_mem_burst_responder: directed bench for mem_burst_responder with a behavioural memory
module tb_mem_burst_responder;
    localparam int DW = 64;
    localparam int AW = 24;
    localparam int LW = 10;

    logic mem_clk = 1'b0;
    logic rst_n = 1'b0;
    logic rd_burst_req = 1'b0;
    logic [LW-1:0] rd_burst_len = '0;
    logic [AW-1:0] rd_burst_addr = '0;
    logic rd_burst_data_valid;
    logic [DW-1:0] rd_burst_data;
    logic rd_burst_finish;
    logic wr_burst_req = 1'b0;
    logic [LW-1:0] wr_burst_len = '0;
    logic [AW-1:0] wr_burst_addr = '0;
    logic wr_burst_data_req;
    logic [DW-1:0] wr_burst_data = '0;
    logic wr_burst_finish;
    logic [AW-1:0] mem_addr;
    logic mem_we;
    logic [DW-1:0] mem_wdata;
    logic mem_re;
    logic [DW-1:0] mem_rdata = '0;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int re_cnt = 0;
    int ovl = 0;
    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    logic [DW-1:0] rdq[$];
    int rcyc[$];
    int wfin[$];
    int rfin[$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] wpat [8];
    int widx = 0;
    bit wfin_prev = 0, rfin_prev = 0, wreq_prev = 0;

    mem_burst_responder dut (
        .mem_clk(mem_clk),
        .rst_n(rst_n),
        .rd_burst_req(rd_burst_req),
        .rd_burst_len(rd_burst_len),
        .rd_burst_addr(rd_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid),
        .rd_burst_data(rd_burst_data),
        .rd_burst_finish(rd_burst_finish),
        .wr_burst_req(wr_burst_req),
        .wr_burst_len(wr_burst_len),
        .wr_burst_addr(wr_burst_addr),
        .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_data(wr_burst_data),
        .wr_burst_finish(wr_burst_finish),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 mem_clk = ~mem_clk;

    // memory model: unwritten locations read back as {BEEF, 0, addr}
    always @(posedge mem_clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        if (mem_re) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : {16'hBEEF, 24'h0, mem_addr};
    end

    // mid-cycle observation log
    always @(negedge mem_clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
        if (rd_burst_data_valid) begin
            rdq.push_back(rd_burst_data);
            rcyc.push_back(cyc);
        end
        if (wr_burst_finish) wfin.push_back(cyc);
        if (rd_burst_finish) rfin.push_back(cyc);
        if (mem_re) re_cnt++;
        if (mem_we && mem_re) ovl++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one clock: initiator drops req the cycle after finish, and supplies write data one cycle after data_req
    task automatic tick();
        @(posedge mem_clk);
        #1;
        if (wfin_prev) wr_burst_req = 1'b0;
        if (rfin_prev) rd_burst_req = 1'b0;
        if (wreq_prev) begin
            wr_burst_data = wpat[widx];
            widx++;
        end
        wfin_prev = wr_burst_finish;
        rfin_prev = rd_burst_finish;
        wreq_prev = wr_burst_data_req;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_fin(input bit w, input int target, input string tag);
        for (int i = 0; i < 300 && (w ? wfin.size() : rfin.size()) < target; i++) tick();
        chk(tag, w ? wfin.size() : rfin.size(), target);
    endtask

    task automatic both_round(input string tag, input bit rd_first);
        int nw = wfin.size();
        int nr = rfin.size();
        int nq = rdq.size();
        int g;
        widx = 0;
        wpat[0] = 64'h1000_0000_0000_0001;
        wpat[1] = 64'h2000_0000_0000_0002;
        wr_burst_addr = 24'h000300;
        wr_burst_len = 10'd2;
        rd_burst_addr = 24'h000400;
        rd_burst_len = 10'd2;
        wr_burst_req = 1'b1;
        rd_burst_req = 1'b1;
        g = cyc;
        for (int i = 0; i < 300 && (wfin.size() == nw || rfin.size() == nr); i++) tick();
        chk({tag, "_wr_lat"}, 64'(wfin[nw] - g), rd_first ? 64'd10 : 64'd4);
        chk({tag, "_rd_lat"}, 64'(rfin[nr] - g), rd_first ? 64'd4 : 64'd10);
        chk({tag, "_rd_beat0"}, rdq[nq], 64'hBEEF_0000_0000_0400);
        idle(3);
    endtask

    initial begin
        int g, nw, nf, nq, nre;
        logic [DW-1:0] d [4];
        d[0] = 64'h0123_4567_89AB_CDEF;
        d[1] = 64'hFEDC_BA98_7654_3210;
        d[2] = 64'hA5A5_A5A5_5A5A_5A5A;
        d[3] = 64'h0000_0000_0000_0001;

        idle(3);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_strobes", {wr_burst_data_req, rd_burst_data_valid, wr_burst_finish, rd_burst_finish}, 0);
        chk("rst_data", {mem_wdata, rd_burst_data} == '0, 1);
        rst_n = 1'b1;
        idle(2);
        chk("idle_after_rst", {mem_we, mem_re, wr_burst_data_req}, 0);

        both_round("rr_a", 1'b0);

        nw = wa.size();
        nf = wfin.size();
        widx = 0;
        for (int i = 0; i < 4; i++) wpat[i] = d[i];
        wr_burst_addr = 24'h000100;
        wr_burst_len = 10'd4;
        wr_burst_req = 1'b1;
        g = cyc;
        wait_fin(1'b1, nf + 1, "wr_fin_seen");
        chk("wr_lat", 64'(wfin[nf] - g), 6);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wr_addr%0d", i), wa[nw + i], 64'h100 + 64'(i));
            chk($sformatf("wr_data%0d", i), wd[nw + i], d[i]);
        end
        idle(3);
        chk("wr_fin_once", wfin.size() - nf, 1);
        chk("wr_beats", wa.size() - nw, 4);

        both_round("rr_b", 1'b1);

        nq = rdq.size();
        nf = rfin.size();
        rd_burst_addr = 24'h000200;
        rd_burst_len = 10'd3;
        rd_burst_req = 1'b1;
        g = cyc;
        wait_fin(1'b0, nf + 1, "rd_fin_seen");
        chk("rd_beat0", rdq[nq], 64'hBEEF_0000_0000_0200);
        chk("rd_beat1", rdq[nq + 1], 64'hBEEF_0000_0000_0201);
        chk("rd_beat2", rdq[nq + 2], 64'hBEEF_0000_0000_0202);
        chk("rd_beat0_cyc", 64'(rcyc[nq] - g), 2);
        chk("rd_beat2_cyc", 64'(rcyc[nq + 2] - g), 4);
        chk("rd_lat", 64'(rfin[nf] - g), 5);
        idle(3);
        chk("rd_beats", rdq.size() - nq, 3);

        nq = rdq.size();
        nf = rfin.size();
        nre = re_cnt;
        rd_burst_addr = 24'h000500;
        rd_burst_len = 10'd0;
        rd_burst_req = 1'b1;
        g = cyc;
        wait_fin(1'b0, nf + 1, "z_fin_seen");
        chk("z_lat", 64'(rfin[nf] - g), 1);
        idle(3);
        chk("z_no_re", re_cnt - nre, 0);
        chk("z_no_valid", rdq.size() - nq, 0);

        nw = wa.size();
        nf = wfin.size();
        widx = 0;
        for (int i = 0; i < 4; i++) wpat[i] = d[3 - i];
        wr_burst_addr = 24'hFFFFFE;
        wr_burst_len = 10'd4;
        wr_burst_req = 1'b1;
        wait_fin(1'b1, nf + 1, "wrap_fin_seen");
        chk("wrap_addr0", wa[nw], 64'hFFFFFE);
        chk("wrap_addr1", wa[nw + 1], 64'hFFFFFF);
        chk("wrap_addr2", wa[nw + 2], 64'h000000);
        chk("wrap_addr3", wa[nw + 3], 64'h000001);
        chk("wrap_data3", wd[nw + 3], d[0]);
        idle(3);

        nf = rfin.size();
        rd_burst_addr = 24'h000600;
        rd_burst_len = 10'd8;
        rd_burst_req = 1'b1;
        g = cyc;
        while (cyc < g + 3) tick();
        chk("mid_valid_before", rd_burst_data_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_re", mem_re, 0);
        chk("mid_rst_valid", rd_burst_data_valid, 0);
        chk("mid_rst_data", rd_burst_data, 0);
        chk("mid_rst_addr", mem_addr, 0);
        rd_burst_req = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(3);
        chk("mid_rst_no_fin", rfin.size() - nf, 0);

        nq = rdq.size();
        rd_burst_addr = 24'h000200;
        rd_burst_len = 10'd3;
        rd_burst_req = 1'b1;
        g = cyc;
        wait_fin(1'b0, nf + 1, "post_rst_fin_seen");
        chk("post_rst_lat", 64'(rfin[nf] - g), 5);
        chk("post_rst_beat0", rdq[nq], 64'hBEEF_0000_0000_0200);
        idle(3);

        chk("no_we_re_overlap", ovl, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
